// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: fetch FSM encoding, PC_sel codes and instruction field positions
package pc_fetch_unit_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2, HALT = 2'd3} state_e;
   typedef enum logic [1:0] {PC_SEQ = 2'b00, PC_BR = 2'b01, PC_JR = 2'b10, PC_J = 2'b11} pc_sel_e;
   localparam int IMM16_LSB = 0;
   localparam int IMM16_W   = 16;
   localparam int TGT26_LSB = 0;
   localparam int TGT26_W   = 26;
endpackage

// File: rtl/pc_fetch_unit_npc_calc.sv
// npc_calc: combinational next-PC selection for sequential, branch, jr and j/jal
module npc_calc
   import pc_fetch_unit_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic [1:0]  PC_sel,
   input  logic        br_cond,
   input  logic [31:0] rs_data,
   output logic [31:0] npc
);
   logic [31:0]        seq;
   logic [31:0]        br_off;
   logic [IMM16_W-1:0] imm;
   logic [TGT26_W-1:0] tgt;
   assign seq    = pc + 32'd4;
   assign imm    = instr[IMM16_LSB +: IMM16_W];
   assign tgt    = instr[TGT26_LSB +: TGT26_W];
   assign br_off = {{(32-IMM16_W-2){imm[IMM16_W-1]}}, imm, 2'b00};
   assign npc    = (PC_sel == PC_JR)            ? rs_data :
                   (PC_sel == PC_J)             ? {seq[31:28], tgt, 2'b00} :
                   (PC_sel == PC_BR && br_cond) ? seq + br_off : seq;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and fetch/execute sequencer over a variable-latency instruction memory
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  PC_sel,
   input  logic        br_cond,
   input  logic [31:0] rs_data,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        addr_err
);
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, instr_q, instr_d, npc;
   logic        err_q, err_d;
   npc_calc u_npc (
      .pc      (pc_q),
      .instr   (instr_q),
      .PC_sel  (PC_sel),
      .br_cond (br_cond),
      .rs_data (rs_data),
      .npc     (npc)
   );
   // sequencing: fetch until memory answers, execute until the datapath retires, halt on a misaligned target
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      err_d   = err_q;
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: if (imem_rdy) begin
            instr_d = imem_rdata;
            state_d = EXEC;
         end
         EXEC: if (!stall) begin
            if (npc[1:0] != 2'b00) begin
               err_d   = 1'b1;
               state_d = HALT;
            end else begin
               pc_d    = npc;
               state_d = FETCH;
            end
         end
         default: ;
      endcase
   end
   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         err_q   <= err_d;
      end
   end
   assign imem_req    = state_q == FETCH;
   assign instr_valid = state_q == EXEC;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign addr_err    = err_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized fetch/execute stimulus with a scoreboard fed by a spec-level PC model
module tb_pc_fetch_unit;
   import pc_fetch_unit_pkg::*;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
   typedef struct {logic [1:0] sel; logic br; logic [31:0] rs; int nstall;} dir_t;
   logic        clk = 0, rst_n = 1, br_cond = 0, stall = 0, imem_rdy = 0;
   logic [1:0]  PC_sel = 0;
   logic [31:0] rs_data = 0, imem_rdata = 0;
   logic        imem_req, instr_valid, addr_err;
   logic [31:0] imem_addr, instr, pc, pc_plus4;
   int          n_chk = 0, n_pass = 0;
   exp_t        exp_q[$];
   dir_t        dir_q[$];
   logic [31:0] ovr[logic [31:0]];
   logic [31:0] m_pc = RST_PC, halt_pc = 0, m_npc;
   int          lat_cfg = 0, cur_lat = 0, wait_cnt = 0, stall_left = 0, n_ret = 0, run = 0;
   logic        exp_halt = 0, drv_prev = 0, mon_prev = 0, en = 0;
   exp_t        cur;
   dir_t        cur_dir;

   always #5 clk = ~clk;

   pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .PC_sel(PC_sel), .br_cond(br_cond), .rs_data(rs_data),
      .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
      .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid), .pc(pc),
      .pc_plus4(pc_plus4), .addr_err(addr_err)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ovr.exists(a) ? ovr[a] : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] ins, input dir_t d);
      logic [31:0] seq = p + 32'd4;
      int off = int'($signed(ins[15:0])) * 4;
      case (d.sel)
         PC_BR:   return d.br ? seq + off : seq;
         PC_JR:   return d.rs;
         PC_J:    return (seq & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
         default: return seq;
      endcase
   endfunction

   function automatic dir_t rand_dir();
      int r = $urandom_range(9, 0);
      dir_t d;
      d.sel    = r < 5 ? PC_SEQ : r < 8 ? PC_BR : r == 8 ? PC_JR : PC_J;
      d.br     = 1'($urandom);
      d.rs     = $urandom & 32'hFFFF_FFFC;
      d.nstall = $urandom_range(2, 0);
      return d;
   endfunction

   // instruction memory: per-request latency, random junk whenever not answering
   always @(negedge clk) begin
      #1;
      if (imem_req) begin
         if (wait_cnt == 0) cur_lat = lat_cfg < 0 ? int'($urandom_range(3, 0)) : lat_cfg;
         imem_rdy   = wait_cnt >= cur_lat;
         imem_rdata = imem_rdy ? mem_word(imem_addr) : $urandom;
         wait_cnt++;
      end else begin
         wait_cnt   = 0;
         imem_rdy   = 1'($urandom);
         imem_rdata = $urandom;
      end
   end

   // datapath driver: stalls, then retires with a decision and pushes the expected next instruction
   always @(negedge clk) begin
      #1;
      stall   = 1'b0;
      PC_sel  = 2'($urandom);
      br_cond = 1'($urandom);
      rs_data = $urandom;
      if (en && rst_n && instr_valid) begin
         if (!drv_prev) begin
            if (dir_q.size() > 0) cur_dir = dir_q.pop_front();
            else cur_dir = rand_dir();
            stall_left = cur_dir.nstall;
         end
         if (stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
         end else begin
            PC_sel  = cur_dir.sel;
            br_cond = cur_dir.br;
            rs_data = cur_dir.rs;
            m_npc   = model_npc(m_pc, mem_word(m_pc), cur_dir);
            n_ret++;
            if (m_npc[1:0] != 2'b00) begin
               exp_halt = 1'b1;
               halt_pc  = m_pc;
            end else begin
               m_pc = m_npc;
               exp_q.push_back('{m_npc, mem_word(m_npc)});
            end
         end
      end
      drv_prev = en && rst_n && instr_valid;
   end

   // monitor: pops one expected instruction per EXEC episode and checks fetch/exec/halt outputs
   always @(negedge clk) begin
      if (!en || !rst_n) begin
         mon_prev = 1'b0;
         run      = 0;
      end else begin
         if (instr_valid) begin
            if (!mon_prev) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_exec: pc %h executing with no instruction expected", pc);
               end else cur = exp_q.pop_front();
            end
            check("exec_pc", pc, cur.pc);
            check("exec_instr", instr, cur.instr);
            check("pc_plus4", pc_plus4, cur.pc + 32'd4);
            check("req_in_exec", 32'(imem_req), 32'd0);
            check("err_in_exec", 32'(addr_err), 32'd0);
         end
         if (imem_req) begin
            run++;
            if (exp_q.size() > 0) check("fetch_addr", imem_addr, exp_q[0].pc);
         end else if (run > 0) begin
            if (instr_valid) check("fetch_cycles", 32'(run), 32'(cur_lat + 1));
            run = 0;
         end
         if (exp_halt) begin
            check("halt_err", 32'(addr_err), 32'd1);
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_valid", 32'(instr_valid), 32'd0);
            check("halt_pc", pc, halt_pc);
         end
         mon_prev = instr_valid;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_pc", pc, RST_PC);
      check("rst_instr", instr, 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_err", 32'(addr_err), 32'd0);
      exp_q.delete();
      dir_q.delete();
      exp_halt   = 1'b0;
      m_pc       = RST_PC;
      stall_left = 0;
      exp_q.push_back('{RST_PC, mem_word(RST_PC)});
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_ret(input int n);
      int c = 0;
      while (n_ret < n && c < 5000) begin
         @(negedge clk);
         c++;
      end
      n_chk++;
      if (n_ret >= n) n_pass++;
      else $display("FAIL retire_timeout: retired %0d required %0d", n_ret, n);
   endtask

   initial begin
      int cnt, c;
      ovr[32'h0000_0010] = 32'h1000_FFFE;
      ovr[32'h1000_0004] = 32'h0800_0100;
      en = 1'b1;
      do_reset();
      dir_q.push_back('{PC_SEQ, 1'b0, 32'd0, 0});
      dir_q.push_back('{PC_SEQ, 1'b0, 32'd0, 0});
      dir_q.push_back('{PC_SEQ, 1'b0, 32'd0, 0});
      dir_q.push_back('{PC_SEQ, 1'b0, 32'd0, 0});
      dir_q.push_back('{PC_BR, 1'b1, 32'd0, 0});
      dir_q.push_back('{PC_SEQ, 1'b0, 32'd0, 0});
      dir_q.push_back('{PC_BR, 1'b0, 32'd0, 0});
      dir_q.push_back('{PC_JR, 1'b0, 32'h1000_0004, 0});
      dir_q.push_back('{PC_J, 1'b0, 32'd0, 0});
      dir_q.push_back('{PC_JR, 1'b0, 32'h0000_2000, 0});
      lat_cfg = 0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("c1_req", 32'(imem_req), 32'd1);
      check("c1_addr", imem_addr, 32'h0);
      check("c1_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check("c2_valid", 32'(instr_valid), 32'd1);
      @(negedge clk);
      check("c3_req", 32'(imem_req), 32'd1);
      check("c3_addr", imem_addr, 32'h4);
      @(negedge clk);
      check("c4_valid", 32'(instr_valid), 32'd1);
      @(negedge clk);
      check("c5_addr", imem_addr, 32'h8);
      wait_ret(10);
      lat_cfg = 3;
      wait_ret(n_ret + 4);
      lat_cfg = -1;
      wait_ret(n_ret + 300);
      dir_q.push_back('{PC_JR, 1'b0, 32'h0000_2002, 0});
      wait_ret(n_ret + 1);
      repeat (6) @(negedge clk);
      check("halt_sticky", 32'(addr_err), 32'd1);
      lat_cfg = 0;
      do_reset();
      dir_q.push_back('{PC_SEQ, 1'b0, 32'd0, 5});
      dir_q.push_back('{PC_SEQ, 1'b0, 32'd0, 30});
      #2 rst_n = 1'b1;
      c = 0;
      while (!instr_valid && c < 10) begin
         @(negedge clk);
         c++;
      end
      cnt = 0;
      while (instr_valid && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check("stall_exec_cycles", 32'(cnt), 32'd6);
      c = 0;
      while (!instr_valid && c < 10) begin
         @(negedge clk);
         c++;
      end
      repeat (3) @(negedge clk);
      check("mid_stall_pc", pc, 32'h4);
      do_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
